// File: rtl/ariane_pkg.sv
// Shared core types: fence-class operation encoding produced by commit-path decode,
// plus small helpers describing which side effects each fence op needs.
package ariane_pkg;

  typedef enum logic [1:0] {
    FENCE        = 2'd0,
    FENCE_I      = 2'd1,
    SFENCE_VMA   = 2'd2,
    DCACHE_FLUSH = 2'd3
  } fence_op_t;

  function automatic logic fence_needs_dflush(fence_op_t op);
    return op != SFENCE_VMA;
  endfunction

  function automatic logic fence_flushes_icache(fence_op_t op);
    return (op == FENCE_I) || (op == DCACHE_FLUSH);
  endfunction

endpackage

// File: rtl/fence_watchdog.sv
// D$-flush watchdog: counts unacknowledged DFLUSH cycles and raises a sticky flag
// once the count reaches TIMEOUT_CYCLES. Only instantiated with FENCE_SEQ_TIMEOUT_EN.
module fence_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic ack,
  output logic timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;
  logic          timeout_q;

  // Held at zero outside DFLUSH, so every DFLUSH entry starts counting from 0.
  // The flag sets on the same edge the count reaches LIMIT; the count saturates there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (!enable) begin
      cnt_q <= '0;
    end else if (!ack && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LIMIT - 1'b1) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/fence_sequencer.sv
// Orders fence side effects: store drain -> D$ flush handshake -> I$/TLB flush -> pipeline flush.
// Optional D$-flush watchdog compiled in with FENCE_SEQ_TIMEOUT_EN.
module fence_sequencer
  import ariane_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  input  logic [1:0] req_op_i,
  output logic       req_ready_o,
  input  logic       no_st_pending_i,
  output logic       dcache_flush_o,
  input  logic       dcache_flush_ack_i,
  output logic       icache_flush_o,
  output logic       tlb_flush_o,
  output logic       flush_pipeline_o,
  output logic       busy_o,
  output logic       timeout_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_DFLUSH,
    ST_ISSUE,
    ST_DONE
  } state_e;

  state_e    state_q, state_d;
  fence_op_t op_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= FENCE;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid_i) op_q <= fence_op_t'(req_op_i);
    end
  end

  // Outputs depend on state_q/op_q only, never directly on inputs.
  always_comb begin
    state_d          = state_q;
    req_ready_o      = 1'b0;
    dcache_flush_o   = 1'b0;
    icache_flush_o   = 1'b0;
    tlb_flush_o      = 1'b0;
    flush_pipeline_o = 1'b0;
    busy_o           = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!req_valid_i) state_d = ST_IDLE;
        else if (no_st_pending_i) state_d = fence_needs_dflush(op_q) ? ST_DFLUSH : ST_ISSUE;
      end
      ST_DFLUSH: begin
        dcache_flush_o = 1'b1;
        if (dcache_flush_ack_i) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        flush_pipeline_o = 1'b1;
        icache_flush_o   = fence_flushes_icache(op_q);
        tlb_flush_o      = (op_q == SFENCE_VMA);
        state_d          = ST_DONE;
      end
      ST_DONE: begin
        req_ready_o = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef FENCE_SEQ_TIMEOUT_EN
  fence_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk_i),
    .rst    (rst_i),
    .enable (state_q == ST_DFLUSH),
    .ack    (dcache_flush_ack_i),
    .timeout(timeout_o)
  );
`else
  assign timeout_o = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

endmodule
